// File: rtl/pipe_pkg.sv
// Shared definitions for the pipeline stage registers: control bit layout and
// the stage payload carried from EX to MEM in the default core configuration.
package pipe_pkg;

    localparam int CTRL_W        = 3;
    localparam int CTRL_REGWRITE = 0;
    localparam int CTRL_MEMREAD  = 1;
    localparam int CTRL_MEMWRITE = 2;

    localparam int DATA_W_DEF = 32;
    localparam int RD_W_DEF   = 5;
    localparam int OPC_W_DEF  = 12;

    typedef struct packed {
        logic [DATA_W_DEF-1:0] alu;
        logic [DATA_W_DEF-1:0] rs2;
        logic [RD_W_DEF-1:0]   rd;
        logic                  rd_zero;
        logic [OPC_W_DEF-1:0]  opcode;
        logic [CTRL_W-1:0]     ctrl;
    } stage_payload_t;

endpackage

// File: rtl/pipe_skid_reg.sv
// Generic 2-entry skid register: main entry drives the output, skid entry
// absorbs one extra beat so in_ready_o depends only on registered state.
module pipe_skid_reg #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         flush_i,
    input  logic         in_valid_i,
    output logic         in_ready_o,
    input  logic [W-1:0] in_data_i,
    output logic         out_valid_o,
    input  logic         out_ready_i,
    output logic [W-1:0] out_data_o,
    output logic [1:0]   occupancy_o
);

    logic         main_valid_q, main_valid_d;
    logic         skid_valid_q, skid_valid_d;
    logic [W-1:0] main_data_q, main_data_d;
    logic [W-1:0] skid_data_q, skid_data_d;
    logic         accept;
    logic         pop;

    assign in_ready_o  = !skid_valid_q;
    assign out_valid_o = main_valid_q;
    assign out_data_o  = main_data_q;
    assign occupancy_o = {1'b0, main_valid_q} + {1'b0, skid_valid_q};

    assign accept = in_valid_i && !skid_valid_q;
    assign pop    = main_valid_q && out_ready_i;

    always_comb begin
        main_valid_d = main_valid_q;
        skid_valid_d = skid_valid_q;
        main_data_d  = main_data_q;
        skid_data_d  = skid_data_q;
        // Flush only drops the valid bits; stale data is harmless once gated.
        if (flush_i) begin
            main_valid_d = 1'b0;
            skid_valid_d = 1'b0;
        end else if (!main_valid_q) begin
            if (accept) begin
                main_valid_d = 1'b1;
                main_data_d  = in_data_i;
            end
        end else if (!skid_valid_q) begin
            if (pop && accept) begin
                main_data_d = in_data_i;
            end else if (pop) begin
                main_valid_d = 1'b0;
            end else if (accept) begin
                skid_valid_d = 1'b1;
                skid_data_d  = in_data_i;
            end
        end else if (pop) begin
            main_data_d  = skid_data_q;
            skid_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            main_valid_q <= 1'b0;
            skid_valid_q <= 1'b0;
            main_data_q  <= '0;
            skid_data_q  <= '0;
        end else begin
            main_valid_q <= main_valid_d;
            skid_valid_q <= skid_valid_d;
            main_data_q  <= main_data_d;
            skid_data_q  <= skid_data_d;
        end
    end

endmodule

// File: rtl/ex_mem_skid_stage.sv
// EX/MEM boundary: skid-buffered handshake stage that records rd==0 at capture
// and gates control to a safe bubble whenever no entry is held.
module ex_mem_skid_stage #(
    parameter int DATA_W = 32,
    parameter int RD_W   = 5,
    parameter int OPC_W  = 12,
    parameter int CTRL_W = pipe_pkg::CTRL_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_alu,
    input  logic [DATA_W-1:0] in_rs2,
    input  logic [RD_W-1:0]   in_rd,
    input  logic [OPC_W-1:0]  in_opcode,
    input  logic [CTRL_W-1:0] in_ctrl,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_alu,
    output logic [DATA_W-1:0] out_rs2,
    output logic [RD_W-1:0]   out_rd,
    output logic              out_rd_zero,
    output logic [OPC_W-1:0]  out_opcode,
    output logic [CTRL_W-1:0] out_ctrl,
    output logic [1:0]        occupancy
);

    typedef struct packed {
        logic [DATA_W-1:0] alu;
        logic [DATA_W-1:0] rs2;
        logic [RD_W-1:0]   rd;
        logic              rd_zero;
        logic [OPC_W-1:0]  opcode;
        logic [CTRL_W-1:0] ctrl;
    } payload_t;

    localparam int PAYLOAD_W = $bits(payload_t);

    payload_t in_pl;
    payload_t out_pl;

    always_comb begin
        in_pl         = '0;
        in_pl.alu     = in_alu;
        in_pl.rs2     = in_rs2;
        in_pl.rd      = in_rd;
        in_pl.rd_zero = (in_rd == '0);
        in_pl.opcode  = in_opcode;
        in_pl.ctrl    = in_ctrl;
    end

    pipe_skid_reg #(
        .W (PAYLOAD_W)
    ) u_skid (
        .clk         (clk),
        .rst         (rst),
        .flush_i     (flush),
        .in_valid_i  (in_valid),
        .in_ready_o  (in_ready),
        .in_data_i   (in_pl),
        .out_valid_o (out_valid),
        .out_ready_i (out_ready),
        .out_data_o  (out_pl),
        .occupancy_o (occupancy)
    );

    assign out_alu    = out_pl.alu;
    assign out_rs2    = out_pl.rs2;
    assign out_rd     = out_pl.rd;
    assign out_opcode = out_pl.opcode;
    // Bubbles must never write the register file or touch memory.
    assign out_ctrl    = out_valid ? out_pl.ctrl : '0;
    assign out_rd_zero = out_valid ? out_pl.rd_zero : 1'b1;

endmodule

// File: tb/tb_ex_mem_skid_stage.sv
// Directed bench for ex_mem_skid_stage: reset, streaming, backpressure,
// bubble gating, flush and rd_zero tracking with hand-computed expectations.
module tb_ex_mem_skid_stage;

    logic        clk = 1'b0;
    logic        rst;
    logic        flush;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_alu;
    logic [31:0] in_rs2;
    logic [4:0]  in_rd;
    logic [11:0] in_opcode;
    logic [2:0]  in_ctrl;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_alu;
    logic [31:0] out_rs2;
    logic [4:0]  out_rd;
    logic        out_rd_zero;
    logic [11:0] out_opcode;
    logic [2:0]  out_ctrl;
    logic [1:0]  occupancy;

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    ex_mem_skid_stage dut (
        .clk         (clk),
        .rst         (rst),
        .flush       (flush),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .in_alu      (in_alu),
        .in_rs2      (in_rs2),
        .in_rd       (in_rd),
        .in_opcode   (in_opcode),
        .in_ctrl     (in_ctrl),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_alu     (out_alu),
        .out_rs2     (out_rs2),
        .out_rd      (out_rd),
        .out_rd_zero (out_rd_zero),
        .out_opcode  (out_opcode),
        .out_ctrl    (out_ctrl),
        .occupancy   (occupancy)
    );

    task automatic drive(input logic v, input logic [31:0] alu, input logic [4:0] rd,
                         input logic [2:0] ctrl);
        in_valid  = v;
        in_alu    = alu;
        in_rs2    = ~alu;
        in_rd     = rd;
        in_opcode = alu[11:0] ^ 12'h5A5;
        in_ctrl   = ctrl;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        #3;
        tests++;
        if (out_valid !== 1'b0 || out_ctrl !== 3'b000 || out_rd_zero !== 1'b1 ||
            occupancy !== 2'd0 || in_ready !== 1'b1 || out_alu !== 32'h0 ||
            out_rs2 !== 32'h0 || out_rd !== 5'd0 || out_opcode !== 12'h0) begin
            fails++;
            $display("FAIL reset_initial: valid=%b ctrl=%b rdz=%b occ=%0d rdy=%b alu=%h rs2=%h rd=%0d opc=%h; want 0 0 1 0 1 and zero data",
                     out_valid, out_ctrl, out_rd_zero, occupancy, in_ready, out_alu, out_rs2, out_rd, out_opcode);
        end
        @(negedge clk);
        rst = 1'b0;
        tick();
    endtask

    task automatic test_streaming();
        out_ready = 1'b1;
        for (int i = 0; i < 10; i++) begin
            if (i < 8) drive(1'b1, 32'h10 + i, 5'd3, 3'b001);
            else       drive(1'b0, 32'h0, 5'd0, 3'b000);
            tick();
            tests++;
            if (i < 8) begin
                if (out_valid !== 1'b1 || out_alu !== 32'h10 + i || out_rs2 !== ~(32'h10 + i) ||
                    out_ctrl !== 3'b001 || in_ready !== 1'b1 || occupancy !== 2'd1) begin
                    fails++;
                    $display("FAIL stream_%0d: valid=%b alu=%h rs2=%h ctrl=%b rdy=%b occ=%0d; want 1 %h %h 001 1 1",
                             i, out_valid, out_alu, out_rs2, out_ctrl, in_ready, occupancy,
                             32'h10 + i, ~(32'h10 + i));
                end
            end else begin
                if (out_valid !== 1'b0 || occupancy !== 2'd0) begin
                    fails++;
                    $display("FAIL stream_drain_%0d: valid=%b occ=%0d; want 0 0", i, out_valid, occupancy);
                end
            end
        end
    endtask

    task automatic test_backpressure();
        out_ready = 1'b0;
        drive(1'b1, 32'hA, 5'd1, 3'b001);
        tick();
        drive(1'b1, 32'hB, 5'd2, 3'b010);
        tick();
        drive(1'b0, 32'h0, 5'd0, 3'b000);
        tests++;
        if (occupancy !== 2'd2 || in_ready !== 1'b0 || out_alu !== 32'hA || out_valid !== 1'b1) begin
            fails++;
            $display("FAIL bp_full: occ=%0d rdy=%b alu=%h valid=%b; want 2 0 0000000a 1",
                     occupancy, in_ready, out_alu, out_valid);
        end
        // Stalled input while full must not be captured.
        drive(1'b1, 32'hEE, 5'd7, 3'b100);
        tick();
        drive(1'b0, 32'h0, 5'd0, 3'b000);
        tests++;
        if (occupancy !== 2'd2 || out_alu !== 32'hA || in_ready !== 1'b0) begin
            fails++;
            $display("FAIL bp_hold: occ=%0d alu=%h rdy=%b; want 2 0000000a 0", occupancy, out_alu, in_ready);
        end
        out_ready = 1'b1;
        tick();
        tests++;
        if (out_valid !== 1'b1 || out_alu !== 32'hB || out_ctrl !== 3'b010 || occupancy !== 2'd1 ||
            in_ready !== 1'b1) begin
            fails++;
            $display("FAIL bp_pop1: valid=%b alu=%h ctrl=%b occ=%0d rdy=%b; want 1 0000000b 010 1 1",
                     out_valid, out_alu, out_ctrl, occupancy, in_ready);
        end
        tick();
        tests++;
        if (out_valid !== 1'b0 || occupancy !== 2'd0) begin
            fails++;
            $display("FAIL bp_pop2: valid=%b occ=%0d; want 0 0", out_valid, occupancy);
        end
    endtask

    task automatic test_full_pop_with_input();
        out_ready = 1'b0;
        drive(1'b1, 32'h21, 5'd1, 3'b001);
        tick();
        drive(1'b1, 32'h22, 5'd1, 3'b001);
        tick();
        out_ready = 1'b1;
        drive(1'b1, 32'h23, 5'd1, 3'b001);
        tick();
        tests++;
        if (out_alu !== 32'h22 || occupancy !== 2'd1 || in_ready !== 1'b1) begin
            fails++;
            $display("FAIL full_pop_in: alu=%h occ=%0d rdy=%b; want 00000022 1 1", out_alu, occupancy, in_ready);
        end
        // 0x23 was refused last cycle; re-presenting it now is accepted.
        tick();
        drive(1'b0, 32'h0, 5'd0, 3'b000);
        tests++;
        if (out_alu !== 32'h23 || out_valid !== 1'b1 || occupancy !== 2'd1) begin
            fails++;
            $display("FAIL full_pop_retry: alu=%h valid=%b occ=%0d; want 00000023 1 1", out_alu, out_valid, occupancy);
        end
        tick();
    endtask

    task automatic test_bubble();
        out_ready = 1'b1;
        drive(1'b0, 32'h55, 5'd9, 3'b111);
        tick();
        tick();
        tests++;
        if (out_valid !== 1'b0 || out_ctrl !== 3'b000 || out_rd_zero !== 1'b1 || occupancy !== 2'd0) begin
            fails++;
            $display("FAIL bubble: valid=%b ctrl=%b rdz=%b occ=%0d; want 0 000 1 0",
                     out_valid, out_ctrl, out_rd_zero, occupancy);
        end
        drive(1'b0, 32'h0, 5'd0, 3'b000);
    endtask

    task automatic test_flush();
        out_ready = 1'b0;
        drive(1'b1, 32'h31, 5'd4, 3'b001);
        tick();
        drive(1'b1, 32'h32, 5'd4, 3'b001);
        tick();
        tests++;
        if (occupancy !== 2'd2) begin
            fails++;
            $display("FAIL flush_prefill: occ=%0d; want 2", occupancy);
        end
        flush = 1'b1;
        out_ready = 1'b1;
        drive(1'b1, 32'hC, 5'd4, 3'b111);
        tick();
        flush = 1'b0;
        drive(1'b0, 32'h0, 5'd0, 3'b000);
        tests++;
        if (occupancy !== 2'd0 || in_ready !== 1'b1 || out_valid !== 1'b0 || out_ctrl !== 3'b000) begin
            fails++;
            $display("FAIL flush_full: occ=%0d rdy=%b valid=%b ctrl=%b; want 0 1 0 000",
                     occupancy, in_ready, out_valid, out_ctrl);
        end
        for (int i = 0; i < 3; i++) begin
            tick();
            tests++;
            if (out_valid !== 1'b0) begin
                fails++;
                $display("FAIL flush_leak_%0d: valid=%b alu=%h; want valid 0", i, out_valid, out_alu);
            end
        end
        // Flush with the stage empty still drops an offered input.
        flush = 1'b1;
        drive(1'b1, 32'hD, 5'd4, 3'b001);
        tick();
        flush = 1'b0;
        drive(1'b0, 32'h0, 5'd0, 3'b000);
        tests++;
        if (occupancy !== 2'd0 || out_valid !== 1'b0) begin
            fails++;
            $display("FAIL flush_empty: occ=%0d valid=%b; want 0 0", occupancy, out_valid);
        end
    endtask

    task automatic test_rd_zero();
        out_ready = 1'b1;
        drive(1'b1, 32'h41, 5'd0, 3'b001);
        tick();
        drive(1'b1, 32'h42, 5'd5, 3'b101);
        tests++;
        if (out_valid !== 1'b1 || out_rd_zero !== 1'b1 || out_rd !== 5'd0 || out_ctrl !== 3'b001) begin
            fails++;
            $display("FAIL rdz_first: valid=%b rdz=%b rd=%0d ctrl=%b; want 1 1 0 001",
                     out_valid, out_rd_zero, out_rd, out_ctrl);
        end
        tick();
        drive(1'b0, 32'h0, 5'd0, 3'b000);
        tests++;
        if (out_valid !== 1'b1 || out_rd_zero !== 1'b0 || out_rd !== 5'd5 || out_ctrl !== 3'b101 ||
            out_opcode !== (12'h042 ^ 12'h5A5)) begin
            fails++;
            $display("FAIL rdz_second: valid=%b rdz=%b rd=%0d ctrl=%b opc=%h; want 1 0 5 101 %h",
                     out_valid, out_rd_zero, out_rd, out_ctrl, out_opcode, 12'h042 ^ 12'h5A5);
        end
        tick();
    endtask

    task automatic test_reset_midstream();
        out_ready = 1'b0;
        drive(1'b1, 32'h51, 5'd6, 3'b111);
        tick();
        drive(1'b1, 32'h52, 5'd6, 3'b111);
        tick();
        drive(1'b0, 32'h0, 5'd0, 3'b000);
        tests++;
        if (occupancy !== 2'd2) begin
            fails++;
            $display("FAIL rst_prefill: occ=%0d; want 2", occupancy);
        end
        #2;
        rst = 1'b1;
        #1;
        tests++;
        if (out_valid !== 1'b0 || out_ctrl !== 3'b000 || occupancy !== 2'd0 || in_ready !== 1'b1 ||
            out_rd_zero !== 1'b1 || out_alu !== 32'h0 || out_rd !== 5'd0) begin
            fails++;
            $display("FAIL rst_mid: valid=%b ctrl=%b occ=%0d rdy=%b rdz=%b alu=%h rd=%0d; want 0 000 0 1 1 0 0",
                     out_valid, out_ctrl, occupancy, in_ready, out_rd_zero, out_alu, out_rd);
        end
        @(negedge clk);
        rst = 1'b0;
        tick();
        tests++;
        if (out_valid !== 1'b0 || occupancy !== 2'd0) begin
            fails++;
            $display("FAIL rst_after: valid=%b occ=%0d; want 0 0", out_valid, occupancy);
        end
    endtask

    initial begin
        rst       = 1'b1;
        flush     = 1'b0;
        out_ready = 1'b0;
        drive(1'b0, 32'h0, 5'd0, 3'b000);
        test_reset();
        test_streaming();
        test_backpressure();
        test_full_pop_with_input();
        test_bubble();
        test_flush();
        test_rd_zero();
        test_reset_midstream();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
